// File: rtl/div16_seq.sv
// Sequential 16-bit unsigned restoring divider.
// A quotient bit is produced each cycle by one sub16pre stage. Division by
// zero skips the iterations and returns a configurable result with a flag.
// The handshake is valid/ready on both the operand side and the result side.

// 17-bit adder with a carry-in of one. When b is the complement of the
// subtrahend, sum is a - subtrahend modulo 2^17.
module sub16pre (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] sum
);

    assign sum = a + b + 17'd1;

endmodule

module div16_seq #(
    parameter logic [15:0] DIV0_Q             = 16'hFFFF,
    parameter bit          DIV0_R_IS_DIVIDEND = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] q_sr_r;      // dividend shifts out at the top, quotient in at the bottom
    logic [15:0] d_r;         // latched divisor
    logic [15:0] rem_r;       // partial remainder, always below d_r
    logic [3:0]  count_r;     // steps left after the current one

    logic [16:0] trial_s;
    logic [16:0] sub_b_s;
    logic [16:0] diff_s;
    logic        borrow_s;
    logic [15:0] rem_next_s;
    logic [15:0] q_next_s;
    logic [15:0] div0_rem_s;

    // Trial value is the remainder with the next dividend bit shifted in.
    // It is always below 2*D, so bit 16 of the difference is an exact borrow.
    assign trial_s = {rem_r, q_sr_r[15]};
    assign sub_b_s = ~{1'b0, d_r};

    sub16pre u_sub (
        .a   (trial_s),
        .b   (sub_b_s),
        .sum (diff_s)
    );

    assign borrow_s   = diff_s[16];
    assign rem_next_s = borrow_s ? trial_s[15:0] : diff_s[15:0];
    assign q_next_s   = {q_sr_r[14:0], ~borrow_s};
    assign div0_rem_s = DIV0_R_IS_DIVIDEND ? dividend : 16'h0000;

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            q_sr_r    <= 16'h0000;
            d_r       <= 16'h0000;
            rem_r     <= 16'h0000;
            count_r   <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= 16'h0000;
            remainder <= 16'h0000;
            div0      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        q_sr_r   <= dividend;
                        d_r      <= divisor;
                        rem_r    <= 16'h0000;
                        in_ready <= 1'b0;
                        if (divisor == 16'h0000) begin
                            // No iterations: the result is known at accept time.
                            state_r   <= DONE;
                            count_r   <= 4'd0;
                            out_valid <= 1'b1;
                            quotient  <= DIV0_Q;
                            remainder <= div0_rem_s;
                            div0      <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            count_r <= 4'd15;
                        end
                    end
                end
                CALC: begin
                    rem_r  <= rem_next_s;
                    q_sr_r <= q_next_s;
                    if (count_r == 4'd0) begin
                        // Final step: publish the result straight from the step logic.
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_next_s;
                        remainder <= rem_next_s;
                        div0      <= 1'b0;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        div0      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    count_r   <= 4'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    div0      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed cases with fixed expected
// values plus a randomised run scored against a / and % reference queue.
module tb_div16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div0;

    // second instance with a zero remainder on divide-by-zero
    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] quotient2;
    logic [15:0] remainder2;
    logic        div0_2;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        d0;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   rand_done;

    div16_seq #(.DIV0_Q(16'hFFFF), .DIV0_R_IS_DIVIDEND(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div0(div0)
    );

    div16_seq #(.DIV0_Q(16'hFFFF), .DIV0_R_IS_DIVIDEND(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid2),
        .out_ready(out_ready2), .quotient(quotient2), .remainder(remainder2),
        .div0(div0_2)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t m;
        if (b == 16'h0000) begin
            m.q  = 16'hFFFF;
            m.r  = a;
            m.d0 = 1'b1;
        end else begin
            m.q  = a / b;
            m.r  = a % b;
            m.d0 = 1'b0;
        end
        return m;
    endfunction

    // Scoreboard: push on the handshake that the next edge will take,
    // pop and compare on each result handshake. Reset discards pending work.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready)
                sb.push_back(model(dividend, divisor));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_quot", {16'h0, quotient}, {16'h0, e.q});
                    check("sb_rem", {16'h0, remainder}, {16'h0, e.r});
                    check("sb_div0", {31'h0, div0}, {31'h0, e.d0});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int n;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        if (!in_ready)
            check("accept_timeout", 32'd0, 32'd1);
        tick;
        in_valid = 1'b0;
    endtask

    // edges after the accepting edge until out_valid is seen
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick;
            cyc++;
        end
        if (!out_valid)
            check("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic [15:0] r, input logic d0,
                           input int lat);
        int cyc;
        out_ready = 1'b0;
        issue(a, b);
        wait_out(cyc);
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_q"}, {16'h0, quotient}, {16'h0, q});
        check({tag, "_r"}, {16'h0, remainder}, {16'h0, r});
        check({tag, "_div0"}, {31'h0, div0}, {31'h0, d0});
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, {31'h0, out_valid}, 32'd0);
        check({tag, "_iready_back"}, {31'h0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        dividend   = 16'h0000;
        divisor    = 16'h0000;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        rand_done  = 1'b0;
        repeat (2) tick;
        rst = 1'b0;

        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_quot", {16'h0, quotient}, 32'd0);
        check("rst_rem", {16'h0, remainder}, 32'd0);
        check("rst_div0", {31'h0, div0}, 32'd0);

        // basic and extreme operands; divide-by-zero result is already
        // visible right after the accepting edge
        run_one("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        run_one("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16);
        run_one("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16);
        run_one("small_big", 16'h1234, 16'hFFFF, 16'h0000, 16'h1234, 1'b0, 16);
        run_one("t16_path", 16'h8000, 16'h8001, 16'h0000, 16'h8000, 1'b0, 16);
        run_one("div0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);

        // divide-by-zero on the zero-remainder instance
        dividend  = 16'd5;
        divisor   = 16'd0;
        check("d0z_ready", {31'h0, in_ready2}, 32'd1);
        in_valid2 = 1'b1;
        tick;
        in_valid2 = 1'b0;
        check("d0z_valid", {31'h0, out_valid2}, 32'd1);
        check("d0z_q", {16'h0, quotient2}, 32'h0000FFFF);
        check("d0z_r", {16'h0, remainder2}, 32'd0);
        check("d0z_flag", {31'h0, div0_2}, 32'd1);
        out_ready2 = 1'b1;
        tick;
        out_ready2 = 1'b0;
        check("d0z_valid_drop", {31'h0, out_valid2}, 32'd0);
        check("d0z_flag_clr", {31'h0, div0_2}, 32'd0);

        // backpressure: result held, busy-time operands ignored
        issue(16'd1000, 16'd33);
        wait_out(cyc);
        check("bp_lat", cyc, 32'd16);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 16'd77 + 16'(i);
            divisor  = 16'd3;
            tick;
            check("bp_in_ready", {31'h0, in_ready}, 32'd0);
            check("bp_out_valid", {31'h0, out_valid}, 32'd1);
            check("bp_quot", {16'h0, quotient}, 32'd30);
            check("bp_rem", {16'h0, remainder}, 32'd10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_done", {31'h0, out_valid}, 32'd0);

        // reset during the eighth iteration
        issue(16'd60000, 16'd7);
        repeat (8) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("mid_rst_sb_flushed", sb.size(), 32'd0);
        run_one("after_rst", 16'd60000, 16'd7, 16'd8571, 16'd3, 1'b0, 16);

        // randomised traffic with random gaps and sink stalls
        fork
            begin
                logic [15:0] a;
                logic [15:0] b;
                for (int i = 0; i < 1500; i++) begin
                    repeat ($urandom_range(0, 3)) tick;
                    a = 16'($urandom_range(0, 65535));
                    case ($urandom_range(0, 9))
                        0:       b = 16'h0000;
                        1:       b = 16'h0001;
                        2:       b = 16'($urandom_range(1, 255));
                        3:       b = (a == 16'hFFFF) ? a : a + 16'($urandom_range(1, 65535 - int'(a)));
                        default: b = 16'($urandom_range(0, 65535));
                    endcase
                    issue(a, b);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick;
                end
            end
        join

        out_ready = 1'b1;
        repeat (40) tick;
        check("drain_all_results", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
